// File: rtl/seq_shift_add_mul_if.sv
// Operand/product handshake bundle for seq_shift_add_mul.
// master drives operands and out_ready; slave is the multiplier.
interface seq_shift_add_mul_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] P;
  logic               busy;

  modport master (
    output in_valid,
    output A,
    output B,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  P,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  A,
    input  B,
    input  out_ready,
    output in_ready,
    output out_valid,
    output P,
    output busy
  );
endinterface

// File: rtl/seq_shift_add_mul.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per clock.
// Ports: clk, rst_n (async low), bus (slave: in_valid/in_ready/A/B, out_valid/out_ready/P, busy).
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module seq_shift_add_mul #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  seq_shift_add_mul_if.slave bus
);
  localparam int W  = WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic [W-1:0]   mcand;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] p_q;
  logic           rdy_q;
  logic           vld_q;
  logic           busy_q;

  logic [W-1:0]   addend;
  logic [W:0]     carry;
  logic [W-1:0]   psum;
  logic [W:0]     sum;
  logic [2*W-1:0] acc_nxt;
  logic           last;
  logic           accept;
  logic           release_p;
  logic           st_idle;
  logic           st_run;
  logic           st_done;

  assign addend   = acc[0] ? mcand : '0;
  assign carry[0] = 1'b0;

  genvar i;
  generate
    for (i = 0; i < W; i++) begin : g_fa
      fulladder u_fa (
        .a  (acc[W+i]),
        .b  (addend[i]),
        .ci (carry[i]),
        .s  (psum[i]),
        .co (carry[i+1])
      );
    end
  endgenerate

  // Carry-out lands in the top bit as the acc shifts right.
  assign sum     = {carry[W], psum};
  assign acc_nxt = {sum, acc[W-1:1]};

  assign last      = (cnt == CW'(W - 1));
  assign accept    = bus.in_valid && rdy_q;
  assign release_p = bus.out_ready && vld_q;

  assign st_idle = (state == IDLE);
  assign st_run  = (state == RUN);
  assign st_done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mcand  <= '0;
      acc    <= '0;
      cnt    <= '0;
      p_q    <= '0;
      rdy_q  <= 1'b1;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      unique case (1'b1)
        st_idle: begin
          if (accept) begin
            mcand  <= bus.A;
            acc    <= {{W{1'b0}}, bus.B};
            cnt    <= '0;
            state  <= RUN;
            rdy_q  <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        st_run: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            p_q    <= acc_nxt;
            state  <= DONE;
            busy_q <= 1'b0;
            vld_q  <= 1'b1;
          end
        end
        st_done: begin
          if (release_p) begin
            state <= IDLE;
            vld_q <= 1'b0;
            rdy_q <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          rdy_q  <= 1'b1;
          vld_q  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = vld_q;
  assign bus.busy      = busy_q;
  assign bus.P         = p_q;
endmodule
